// File: rtl/uart_pkg.sv
// Shared definitions for the status UART transmitter: frame layout constants,
// FSM state encodings and the frame checksum helper.
package uart_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 5;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_FINISH
  } frame_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

  // Sum is formed 10 bits wide so the carry out of the byte add is visible
  // before being dropped.
  function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c);
    logic [9:0] acc;
    acc = {2'b00, a} + {2'b00, b} + {2'b00, c};
    return acc[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each
// held for DIV clocks. A start on the last stop cycle chains the next byte.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int DIV = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TX,
  output logic       byte_done
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(DIV - 1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    shift_q, shift_d;
  logic          bit_end;

  assign bit_end = (baud_cnt_q == LAST_CNT);
  assign TX      = shift_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SER_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= '1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // The line bit is always shift_q[0]; each bit boundary shifts in a 1 so the
  // register drains to the idle level once the stop bit has gone out.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;

    case (state_q)
      SER_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = 3'd0;
        if (start) begin
          state_d = SER_START;
          shift_d = {1'b1, data, 1'b0};
        end
      end

      SER_START: begin
        if (bit_end) begin
          state_d    = SER_DATA;
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          shift_d    = {1'b1, shift_q[9:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end

      SER_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b1, shift_q[9:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = SER_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end

      SER_STOP: begin
        if (bit_end) begin
          byte_done  = 1'b1;
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          if (start) begin
            state_d = SER_START;
            shift_d = {1'b1, data, 1'b0};
          end else begin
            state_d = SER_IDLE;
            shift_d = '1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d    = SER_IDLE;
        baud_cnt_d = '0;
        bit_idx_d  = 3'd0;
        shift_d    = '1;
      end
    endcase
  end

endmodule

// File: rtl/status_uart_tx.sv
// Game status transmitter: snapshots mstate / player_hp / mon_hp on request
// and sends the frame A5, mstate, player_hp, mon_hp, checksum over 8N1 UART.
module status_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] player_hp,
  input  logic [7:0] mon_hp,
  input  logic [7:0] mstate,
  output logic       busy,
  output logic       done,
  output logic       TX
);

  localparam int DIV = CLK_HZ / BAUD;

  frame_state_e state_q, state_d;
  logic [7:0]   mstate_q, mstate_d;
  logic [7:0]   player_hp_q, player_hp_d;
  logic [7:0]   mon_hp_q, mon_hp_d;
  logic [7:0]   checksum_q, checksum_d;
  logic [2:0]   byte_idx_q, byte_idx_d;
  logic [2:0]   next_idx;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tx_q, tx_d;
  logic         ser_start;
  logic [7:0]   ser_data;
  logic         ser_tx;
  logic         ser_done;
  logic [7:0]   next_byte;

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx_byte (
    .clk       (clk),
    .reset     (reset),
    .start     (ser_start),
    .data      (ser_data),
    .TX        (ser_tx),
    .byte_done (ser_done)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign TX   = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FR_IDLE;
      mstate_q    <= 8'h00;
      player_hp_q <= 8'h00;
      mon_hp_q    <= 8'h00;
      checksum_q  <= 8'h00;
      byte_idx_q  <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      mstate_q    <= mstate_d;
      player_hp_q <= player_hp_d;
      mon_hp_q    <= mon_hp_d;
      checksum_q  <= checksum_d;
      byte_idx_q  <= byte_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
    end
  end

  assign next_idx = byte_idx_q + 3'd1;

  always_comb begin
    next_byte = FRAME_HDR;
    case (next_idx)
      3'd1:    next_byte = mstate_q;
      3'd2:    next_byte = player_hp_q;
      3'd3:    next_byte = mon_hp_q;
      3'd4:    next_byte = checksum_q;
      default: next_byte = FRAME_HDR;
    endcase
  end

  // The header starts straight from the accept, so the serializer and the
  // output flop together place the start bit one cycle after the accept edge.
  // busy/done are registered from the state, lining them up with TX; FINISH
  // therefore already behaves as idle and may accept the next request.
  always_comb begin
    state_d     = state_q;
    mstate_d    = mstate_q;
    player_hp_d = player_hp_q;
    mon_hp_d    = mon_hp_q;
    checksum_d  = checksum_q;
    byte_idx_d  = byte_idx_q;
    ser_start   = 1'b0;
    ser_data    = FRAME_HDR;
    busy_d      = (state_q == FR_SEND);
    done_d      = (state_q == FR_FINISH);
    tx_d        = ser_tx;

    case (state_q)
      FR_IDLE, FR_FINISH: begin
        state_d    = FR_IDLE;
        byte_idx_d = 3'd0;
        if (send) begin
          state_d     = FR_SEND;
          mstate_d    = mstate;
          player_hp_d = player_hp;
          mon_hp_d    = mon_hp;
          checksum_d  = frame_checksum(mstate, player_hp, mon_hp);
          ser_start   = 1'b1;
          ser_data    = FRAME_HDR;
        end
      end

      FR_SEND: begin
        if (ser_done) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d    = FR_FINISH;
            byte_idx_d = 3'd0;
          end else begin
            byte_idx_d = next_idx;
            ser_start  = 1'b1;
            ser_data   = next_byte;
          end
        end
      end

      default: begin
        state_d    = FR_IDLE;
        byte_idx_d = 3'd0;
      end
    endcase
  end

endmodule

// File: doc/status_uart_tx.md
# status_uart_tx

Serial status transmitter for the game top level: on request it snapshots the player HP, monster HP and machine state, then sends them to the host PC as a fixed 5-byte frame over the board's UART TX line (8N1, LSB first). It is the transmit-side counterpart to the key-receiving UART path. It replaces the echo-only drive of `RsTx`, so the host can log the game state.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 9600: line rate. Bit period `DIV = CLK_HZ / BAUD`, using integer truncation (10416 at defaults). `DIV` must be at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `send`  in  1  frame request, sampled every cycle.
- `player_hp`  in  8  player HP; captured on accept.
- `mon_hp`  in  8  monster HP; captured on accept.
- `mstate`  in  8  machine state; captured on accept.
- `busy`  out  1  high while a frame is in flight.
- `done`  out  1  one-cycle pulse when the final stop bit completes.
- `TX`  out  1  serial line, idle high.

## Operation
- Frame bytes, in order: header `0xA5`, `mstate`, `player_hp`, `mon_hp`, checksum.
- Checksum = (`mstate` + `player_hp` + `mon_hp`) mod 256. Sum in a 10-bit accumulator and keep the low 8 bits.
- Each byte is sent as 10 bits: start bit 0, data bits 0 to 7, stop bit 1.
- There is no idle gap between bytes. The start bit of byte n+1 follows the stop bit of byte n immediately.
- Frame FSM states:
  - IDLE: on `send`=1, capture all three inputs into snapshot registers and compute the checksum, then go to SEND.
  - SEND: step a byte index from 0 to 4, handing each byte to the serializer. When the serializer finishes byte 4, go to FINISH.
  - FINISH: assert `done` for one cycle, then return to IDLE.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - A 3-bit bit index counts through DATA.
  - A baud counter counts from 0 to `DIV`-1 for each bit, then wraps.
- `send` while `busy`=1 is ignored. There is no queueing and no latched pending request.
- Input changes after accept do not affect the frame in flight; only the snapshot is transmitted.
- `send` asserted in the same cycle `done` is high is accepted, because the FSM is already in IDLE that cycle.
- Reset asserted at any point, including mid-bit or mid-frame:
  - `TX` goes to 1 immediately (asynchronously).
  - `busy` and `done` go to 0, and all counters and the byte index clear.
  - No partial frame resumes after reset releases.
- Reset values: `TX`=1, `busy`=0, `done`=0, snapshot registers = 0.

## Timing
- Cycle 0 is the rising edge at which `send`=1 is sampled in IDLE.
- Cycle 1: `busy`=1 and `TX`=0 (start bit of the header byte).
- Bit k of the frame (k = 0..49) drives `TX` during cycles 1+k·DIV through (k+1)·DIV.
- Cycle 50·DIV+1: `done`=1 and `busy`=0. `TX` stays 1.
- Accept-to-done latency is 50·DIV+1 cycles.
- Fastest back-to-back rate: the next frame starts 50·DIV+1 cycles after the previous accept.
- `TX` is registered, so there is no combinational path from any input to `TX`.

## Structure
- Shared package `uart_pkg` holds:
  - frame header constant `FRAME_HDR` = 8'hA5;
  - `FRAME_LEN` = 5;
  - the frame-FSM and serializer-FSM state encodings.
- One sub-module, `uart_tx_byte`:
  - ports: `clk`, `reset`, `start`, `data[7:0]`, `TX`, `byte_done`;
  - contains the baud counter and the 10-bit shift logic;
  - parameter `DIV` is passed down from the top.
- The top holds the snapshot registers, checksum, byte mux and frame FSM.

## Test plan
All scenarios use `CLK_HZ`=16 and `BAUD`=1, so `DIV`=16.
- Reset release: `TX`=1, `busy`=0, `done`=0, and they stay that way for 100 cycles with `send`=0.
- Basic frame: `mstate`=0x03, `player_hp`=0x14, `mon_hp`=0x64, pulse `send` → bytes decoded at mid-bit are A5 03 14 64 7B, LSB first with correct start/stop bits. `done` pulses exactly 801 cycles after accept.
- Checksum wrap: `mstate`=0x01, `player_hp`=0xFF, `mon_hp`=0x02 → checksum byte 0x02.
- Busy protection: start a frame, then change all inputs to 0xEE and pulse `send` at cycle 200. The frame is unchanged, there is only one `done`, and no second frame follows.
- Reset mid-frame: assert reset at cycle 300. `TX`=1 and `busy`=0 in the same cycle. After release, `send` produces a full frame that begins with A5.
- Back-to-back: hold `send`=1 continuously → consecutive frames, each accept landing on the `done` cycle, with start bits spaced 801 cycles apart.
